// File: rtl/hex_display_pkg.sv
// Shared constants, FSM states and glyph table for the hex display controller.
// Blink support is enabled by defining HEX_DISPLAY_BLINK_EN.
package hex_display_pkg;

    localparam logic [1:0] ADDR_VALUE  = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    localparam int CTRL_MODE_BIT  = 0;
    localparam int CTRL_BLANK_LSB = 8;
    localparam int CTRL_BLINK_LSB = 16;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LOAD
    } conv_state_t;

    // Active-low segments, bit 0 = segment a
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    function automatic int unsigned pow10(input int n);
        int unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: 20 shift cycles, one load cycle.
// done pulses during the load cycle while bcd holds the final result.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [19:0] bin,
    output logic        busy,
    output logic        done,
    output logic [23:0] bcd
);
    import hex_display_pkg::*;

    conv_state_t state;
    logic [19:0] sh;
    logic [4:0]  cnt;
    logic [23:0] adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < 6; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            sh    <= '0;
            bcd   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh    <= bin;
                        bcd   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bcd <= {adj[22:0], sh[19]};
                    sh  <= {sh[18:0], 1'b0};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd19) begin
                        done  <= 1'b1;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Avalon-MM seven-segment controller with hex and decimal display modes.
// Define HEX_DISPLAY_BLINK_EN to build in per-digit blinking.
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 12_500_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              address,
    input  logic                    write,
    input  logic [31:0]             writedata,
    input  logic                    read,
    output logic [31:0]             readdata,
    output logic                    waitrequest,
    output logic [NUM_DIGITS*7-1:0] hex
);
    import hex_display_pkg::*;

    localparam logic [19:0] MAX_DEC = 20'(pow10(NUM_DIGITS) - 1);

    logic [23:0]              value_q;
    logic                     mode_q;
    logic                     ovf_q;
    logic [NUM_DIGITS-1:0]    blank_q;
    logic [NUM_DIGITS-1:0]    blink_off;
    logic [NUM_DIGITS*7-1:0]  seg_q;
    logic [NUM_DIGITS*7-1:0]  hex_seg;
    logic [NUM_DIGITS*7-1:0]  dec_seg;
    logic [23:0]              next_value;
    logic                     next_mode;
    logic                     wr_ok;
    logic                     reg_wr;
    logic                     conv_busy;
    logic                     conv_done;
    logic [23:0]              conv_bcd;
    logic                     ovf_calc;
    logic                     zero_run;
    logic [31:0]              ctrl_rd;
    logic [31:0]              rd_mux;
    logic                     unused_bits;

    assign unused_bits = ^writedata[31:24];

    assign waitrequest = write & conv_busy;
    assign wr_ok       = write & ~conv_busy;
    assign reg_wr      = wr_ok & (address == ADDR_VALUE || address == ADDR_CTRL);

    assign next_value = (wr_ok && address == ADDR_VALUE) ? writedata[23:0] : value_q;
    assign next_mode  = (wr_ok && address == ADDR_CTRL) ? writedata[CTRL_MODE_BIT] : mode_q;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .reset (reset),
        .start (reg_wr & next_mode),
        .bin   (next_value[19:0]),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign ovf_calc = (value_q[23:20] != 4'd0) || (value_q[19:0] > MAX_DEC);

    // Scan from the top digit so leading zeros blank; digit 0 always shows
    always_comb begin
        hex_seg  = '0;
        dec_seg  = '0;
        zero_run = 1'b1;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            zero_run = zero_run && (conv_bcd[4*d +: 4] == 4'd0);
            dec_seg[7*d +: 7] = (zero_run && d != 0) ? SEG_BLANK : glyph(conv_bcd[4*d +: 4]);
            hex_seg[7*d +: 7] = glyph(next_value[4*d +: 4]);
        end
    end

    always_comb begin
        hex = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            hex[7*d +: 7] = (blank_q[d] || blink_off[d]) ? SEG_BLANK : seg_q[7*d +: 7];
        end
    end

`ifdef HEX_DISPLAY_BLINK_EN
    localparam int CW = $clog2(BLINK_DIV + 1);

    logic [CW-1:0]         blink_cnt;
    logic                  blink_phase;
    logic [NUM_DIGITS-1:0] blink_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            blink_q     <= '0;
        end else begin
            if (wr_ok && address == ADDR_CTRL)
                blink_q <= writedata[CTRL_BLINK_LSB +: NUM_DIGITS];
            if (blink_cnt == CW'(BLINK_DIV - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign blink_off = blink_phase ? blink_q : '0;
`else
    assign blink_off = '0;
`endif

    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[CTRL_MODE_BIT] = mode_q;
        ctrl_rd[CTRL_BLANK_LSB +: NUM_DIGITS] = blank_q;
`ifdef HEX_DISPLAY_BLINK_EN
        ctrl_rd[CTRL_BLINK_LSB +: NUM_DIGITS] = blink_q;
`endif
        case (address)
            ADDR_VALUE:  rd_mux = {8'd0, value_q};
            ADDR_CTRL:   rd_mux = ctrl_rd;
            ADDR_STATUS: rd_mux = {30'd0, ovf_q, conv_busy};
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q  <= '0;
            mode_q   <= 1'b0;
            blank_q  <= '0;
            ovf_q    <= 1'b0;
            readdata <= '0;
            seg_q    <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            if (wr_ok && address == ADDR_VALUE) value_q <= writedata[23:0];
            if (wr_ok && address == ADDR_CTRL) begin
                mode_q  <= writedata[CTRL_MODE_BIT];
                blank_q <= writedata[CTRL_BLANK_LSB +: NUM_DIGITS];
            end
            // Writes are stalled while converting, so these never collide
            if (reg_wr && !next_mode) begin
                seg_q <= hex_seg;
            end else if (conv_done && mode_q) begin
                seg_q <= ovf_calc ? {NUM_DIGITS{SEG_DASH}} : dec_seg;
                ovf_q <= ovf_calc;
            end
            if (read) readdata <= write ? 32'd0 : rd_mux;
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed self-checking bench for hex_display_ctrl (NUM_DIGITS=6, BLINK_DIV=4).
// Blink checks follow HEX_DISPLAY_BLINK_EN as defined for the build.
module tb_hex_display_ctrl;

    localparam logic [6:0] BL = 7'h7F;
    localparam logic [6:0] DS = 7'h3F;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [41:0] hex;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hex_display_ctrl #(.NUM_DIGITS(6), .BLINK_DIV(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .write       (write),
        .writedata   (writedata),
        .read        (read),
        .readdata    (readdata),
        .waitrequest (waitrequest),
        .hex         (hex)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        address = a; writedata = d; write = 1'b1;
        #1;
        n = 0;
        while (waitrequest && n < 100) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 100) check("write_timeout", 64'(n), 64'd0);
        @(posedge clk); #1;
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; read = 1'b1;
        @(posedge clk); #1;
        read = 1'b0;
        d = readdata;
    endtask

    task automatic wait_idle(output logic [31:0] st);
        int n;
        n = 0;
        bus_read(2'd2, st);
        while (st[0] && n < 100) begin
            bus_read(2'd2, st); n++;
        end
        check("idle_timeout", 64'(n < 100), 64'd1);
    endtask

    logic [31:0] rd;
    int          bc;
    logic [6:0]  s [16];
    int          ti;
    logic [6:0]  first, second, expd;

    initial begin
        reset = 1'b1; address = '0; write = 1'b0; writedata = '0; read = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        #1;
        check("reset_hex", 64'(hex), 64'({6{BL}}));
        check("reset_waitreq", 64'(waitrequest), 64'd0);
        bus_read(2'd0, rd); check("reset_value", 64'(rd), 64'd0);
        bus_read(2'd1, rd); check("reset_ctrl", 64'(rd), 64'd0);
        bus_read(2'd2, rd); check("reset_status", 64'(rd), 64'd0);

        // Hex mode
        bus_write(2'd0, 32'h0000ABCD);
        check("hex_abcd", 64'(hex), 64'({7'h40, 7'h40, 7'h08, 7'h03, 7'h46, 7'h21}));
        check("hex_digit0_d", 64'(hex[6:0]), 64'(7'b0100001));
        bus_write(2'd0, 32'hFFABCDEF);
        check("hex_abcdef", 64'(hex), 64'({7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}));
        bus_read(2'd0, rd); check("value_upper_zero", 64'(rd), 64'h00ABCDEF);

        // Write and read together: write wins, read returns 0
        @(negedge clk);
        address = 2'd0; writedata = 32'h111; write = 1'b1; read = 1'b1;
        @(posedge clk); #1;
        write = 1'b0; read = 1'b0;
        check("proto_err_rd", 64'(readdata), 64'd0);
        check("proto_err_hex", 64'(hex), 64'({7'h40, 7'h40, 7'h40, 7'h79, 7'h79, 7'h79}));
        bus_read(2'd0, rd); check("proto_err_value", 64'(rd), 64'h111);

        // Decimal conversion of 123456
        bus_write(2'd0, 32'd123456);
        bus_write(2'd1, 32'h1);
        bus_read(2'd2, rd);
        check("busy_start", 64'(rd[0]), 64'd1);
        check("hex_hold", 64'(hex), 64'({7'h40, 7'h79, 7'h06, 7'h24, 7'h19, 7'h40}));
        bc = rd[0] ? 1 : 0;
        while (rd[0] && bc < 100) begin
            bus_read(2'd2, rd);
            if (rd[0]) bc++;
        end
        check("busy_cycles", 64'(bc), 64'd21);
        check("status_123456", 64'(rd), 64'd0);
        check("dec_123456", 64'(hex), 64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}));

        // Back-to-back write is stalled for the whole conversion
        bus_write(2'd1, 32'h1);
        @(negedge clk);
        address = 2'd3; writedata = 32'hFFFF_FFFF; write = 1'b1;
        #1;
        bc = 0;
        while (waitrequest && bc < 100) begin
            bc++; @(negedge clk); #1;
        end
        @(posedge clk); #1;
        write = 1'b0;
        check("waitreq_cycles", 64'(bc), 64'd21);
        check("dec_123456_again", 64'(hex), 64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}));
        bus_read(2'd3, rd); check("reg3_zero", 64'(rd), 64'd0);

        // Overflow and leading-zero suppression
        bus_write(2'd0, 32'd1000000);
        wait_idle(rd);
        check("ovf_status", 64'(rd), 64'h2);
        check("ovf_dash", 64'(hex), 64'({6{DS}}));
        bus_write(2'd0, 32'd42);
        wait_idle(rd);
        check("dec42_status", 64'(rd), 64'h0);
        check("dec42_hex", 64'(hex), 64'({BL, BL, BL, BL, 7'h19, 7'h24}));
        bus_write(2'd0, 32'd999999);
        wait_idle(rd);
        check("dec999999_status", 64'(rd), 64'h0);
        check("dec999999_hex", 64'(hex), 64'({6{7'h10}}));
        bus_write(2'd0, 32'h00100005);
        wait_idle(rd);
        check("ovf_hi_status", 64'(rd), 64'h2);
        check("ovf_hi_dash", 64'(hex), 64'({6{DS}}));
        bus_write(2'd0, 32'd0);
        wait_idle(rd);
        check("dec0_status", 64'(rd), 64'h0);
        check("dec0_hex", 64'(hex), 64'({BL, BL, BL, BL, BL, 7'h40}));

        // Back to hex without a conversion
        bus_write(2'd1, 32'h0);
        check("to_hex", 64'(hex), 64'({6{7'h40}}));
        bus_read(2'd2, rd); check("to_hex_status", 64'(rd), 64'h0);

        // Reset 10 cycles into SHIFT
        bus_write(2'd0, 32'd123456);
        bus_write(2'd1, 32'h1);
        repeat (10) @(posedge clk);
        #1; reset = 1'b1;
        @(posedge clk); #1;
        check("abort_hex", 64'(hex), 64'({6{BL}}));
        @(negedge clk); reset = 1'b0;
        bus_read(2'd2, rd); check("abort_status", 64'(rd), 64'd0);
        bus_read(2'd0, rd); check("abort_value", 64'(rd), 64'd0);
        repeat (25) @(posedge clk);
        #1;
        check("abort_no_load", 64'(hex), 64'({6{BL}}));

        // Blink / blank
        bus_write(2'd1, 32'h00010200);
        bus_read(2'd1, rd);
`ifdef HEX_DISPLAY_BLINK_EN
        check("ctrl_blink_rd", 64'(rd), 64'h00010200);
`else
        check("ctrl_blink_rd", 64'(rd), 64'h00000200);
`endif
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            s[k] = hex[6:0];
            check("blank_digit1", 64'(hex[13:7]), 64'(BL));
        end
`ifdef HEX_DISPLAY_BLINK_EN
        ti = 0;
        for (int k = 1; k < 6; k++) begin
            if (ti == 0 && s[k] !== s[k-1]) ti = k;
        end
        check("blink_toggle_found", 64'(ti != 0), 64'd1);
        if (ti != 0) begin
            first  = s[ti];
            second = (first == BL) ? 7'h40 : BL;
            check("blink_level", 64'(first == BL || first == 7'h40), 64'd1);
            for (int k = ti; k < ti + 8; k++) begin
                expd = (((k - ti) / 4) % 2 == 0) ? first : second;
                check("blink_digit0", 64'(s[k]), 64'(expd));
            end
        end
`else
        for (int k = 0; k < 16; k++) check("steady_digit0", 64'(s[k]), 64'(7'h40));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
